// File: rtl/alu_cmd_ctrl.sv
// Byte-stream command front-end for a 16-bit ALU: collects opcode/A/B frames, drives the ALU and returns result plus flag byte.
// Optional divide-by-zero guard enabled by defining ALU_CMD_DIV0_CHK_EN.
module alu_cmd_ctrl #(
  parameter int OP_W    = 16,
  parameter int ALU_LAT = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [7:0]      cmd_data,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  output logic [7:0]      rsp_data,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [OP_W-1:0] alu_a,
  output logic [OP_W-1:0] alu_b,
  output logic [3:0]      alu_fun,
  input  logic [OP_W-1:0] alu_out,
  input  logic            arith_flag,
  input  logic            carry_flag,
  input  logic            logic_flag,
  input  logic            cmp_flag,
  input  logic            shift_flag,
  output logic            busy
);

  localparam int NB     = OP_W / 8;
  localparam int FRAME  = 1 + 2 * NB;
  localparam int CNT_W  = $clog2(FRAME);
  localparam int WAIT_W = (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);
  localparam int IDX_W  = $clog2(NB + 2);
  localparam logic [3:0] FUN_NOP = 4'b1111;
`ifdef ALU_CMD_DIV0_CHK_EN
  localparam logic [3:0] FUN_DIV = 4'b0011;
`endif

  typedef enum logic [1:0] {S_CMD, S_EXEC, S_RESP} state_t;

  // Operands arrive LSB first, so each new byte enters at the top and the word slides down.
  function automatic logic [OP_W-1:0] byte_shift_in(input logic [OP_W-1:0] cur, input logic [7:0] b);
    return (cur >> 8) | (OP_W'(b) << (OP_W - 8));
  endfunction

  function automatic logic [7:0] res_byte(input logic [OP_W-1:0] res, input logic [IDX_W-1:0] idx);
    logic [OP_W-1:0] sh;
    sh = res >> {idx, 3'b000};
    return sh[7:0];
  endfunction

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [3:0]        op_q, op_d;
  logic [OP_W-1:0]   a_sh_q, a_sh_d, b_sh_q, b_sh_d;
  logic [OP_W-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [3:0]        alu_fun_q, alu_fun_d;
  logic [OP_W-1:0]   res_q, res_d;
  logic [7:0]        flag_q, flag_d;
  logic [7:0]        rsp_data_q, rsp_data_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              busy_q, busy_d;
  logic [OP_W-1:0]   b_next_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_CMD;
      cnt_q       <= '0;
      wait_q      <= '0;
      idx_q       <= '0;
      op_q        <= 4'h0;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_fun_q   <= FUN_NOP;
      res_q       <= '0;
      flag_q      <= 8'h00;
      rsp_data_q  <= 8'h00;
      rsp_valid_q <= 1'b0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wait_q      <= wait_d;
      idx_q       <= idx_d;
      op_q        <= op_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_fun_q   <= alu_fun_d;
      res_q       <= res_d;
      flag_q      <= flag_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wait_d      = wait_q;
    idx_d       = idx_q;
    op_d        = op_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_fun_d   = alu_fun_q;
    res_d       = res_q;
    flag_d      = flag_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = rsp_valid_q;
    cmd_ready_d = cmd_ready_q;
    b_next_s    = byte_shift_in(b_sh_q, cmd_data);

    case (state_q)
      S_CMD: begin
        if (cmd_valid && cmd_ready_q) begin
          if (cnt_q == CNT_W'(0)) begin
            op_d = cmd_data[3:0];
          end else if (cnt_q <= CNT_W'(NB)) begin
            a_sh_d = byte_shift_in(a_sh_q, cmd_data);
          end else begin
            b_sh_d = b_next_s;
          end
          if (cnt_q == CNT_W'(FRAME - 1)) begin
            cnt_d       = '0;
            cmd_ready_d = 1'b0;
            alu_a_d     = a_sh_q;
            alu_b_d     = b_next_s;
            idx_d       = '0;
            wait_d      = '0;
`ifdef ALU_CMD_DIV0_CHK_EN
            // Divide by zero never reaches the ALU; answer directly with the error frame.
            if ((op_q == FUN_DIV) && (b_next_s == '0)) begin
              res_d   = '1;
              flag_d  = 8'h80;
              state_d = S_RESP;
            end else begin
              alu_fun_d = op_q;
              state_d   = S_EXEC;
            end
`else
            alu_fun_d = op_q;
            state_d   = S_EXEC;
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_EXEC: begin
        if (wait_q == WAIT_W'(ALU_LAT)) begin
          res_d     = alu_out;
          flag_d    = {3'b000, shift_flag, cmp_flag, logic_flag, carry_flag, arith_flag};
          alu_fun_d = FUN_NOP;
          idx_d     = '0;
          state_d   = S_RESP;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_RESP: begin
        // First RESP cycle presents result byte 0; later cycles advance on each accepted byte.
        if (!rsp_valid_q) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = res_byte(res_q, IDX_W'(0));
          idx_d       = IDX_W'(1);
        end else if (rsp_ready) begin
          if (idx_q == IDX_W'(NB + 1)) begin
            rsp_valid_d = 1'b0;
            cmd_ready_d = 1'b1;
            idx_d       = '0;
            state_d     = S_CMD;
          end else if (idx_q == IDX_W'(NB)) begin
            rsp_data_d = flag_q;
            idx_d      = idx_q + IDX_W'(1);
          end else begin
            rsp_data_d = res_byte(res_q, idx_q);
            idx_d      = idx_q + IDX_W'(1);
          end
        end else begin
          rsp_valid_d = rsp_valid_q;
        end
      end
      default: begin
        state_d     = S_CMD;
        cnt_d       = '0;
        cmd_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
        alu_fun_d   = FUN_NOP;
      end
    endcase

    busy_d = (state_d != S_CMD) || (cnt_d != '0);
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_valid = rsp_valid_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_fun   = alu_fun_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Directed bench for alu_cmd_ctrl with a registered 16-bit ALU model and a response-byte scoreboard.
module tb_alu_cmd_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  cmd_data = 8'h00;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  rsp_data;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] alu_a, alu_b, alu_out;
  logic [3:0]  alu_fun;
  logic        arith_flag, carry_flag, logic_flag, cmp_flag, shift_flag;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic watch = 1'b0, saw_non_nop = 1'b0, saw_fun3 = 1'b0;

  always #5 clk = ~clk;

  alu_cmd_ctrl #(.OP_W(16), .ALU_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun), .alu_out(alu_out),
    .arith_flag(arith_flag), .carry_flag(carry_flag), .logic_flag(logic_flag),
    .cmp_flag(cmp_flag), .shift_flag(shift_flag), .busy(busy)
  );

  // Returns {shift, cmp, logic, carry, arith, out[15:0]}.
  function automatic logic [20:0] alu_model(input logic [15:0] a, input logic [15:0] b, input logic [3:0] f);
    logic [16:0] s;
    logic [15:0] o;
    logic [4:0]  fl;
    s = 17'd0; o = 16'd0; fl = 5'd0;
    case (f)
      4'h0: begin s = {1'b0, a} + {1'b0, b}; o = s[15:0]; fl = {4'b0000, 1'b1} | {3'b000, s[16], 1'b0}; end
      4'h1: begin o = a - b; fl = {3'b000, (a < b), 1'b1}; end
      4'h2: begin o = a * b; fl = 5'b00001; end
      4'h3: begin o = (b != 16'd0) ? (a / b) : 16'd0; fl = 5'b00001; end
      4'h4: begin o = a & b;    fl = 5'b00100; end
      4'h5: begin o = a | b;    fl = 5'b00100; end
      4'h6: begin o = ~(a & b); fl = 5'b00100; end
      4'h7: begin o = ~(a | b); fl = 5'b00100; end
      4'h8: begin o = a ^ b;    fl = 5'b00100; end
      4'h9: begin o = ~(a ^ b); fl = 5'b00100; end
      4'hA: begin o = (a == b) ? 16'd1 : 16'd0; fl = 5'b01000; end
      4'hB: begin o = (a > b)  ? 16'd2 : 16'd0; fl = 5'b01000; end
      4'hC: begin o = (a < b)  ? 16'd3 : 16'd0; fl = 5'b01000; end
      4'hD: begin o = a >> 1; fl = 5'b10000; end
      4'hE: begin o = a << 1; fl = 5'b10000; end
      default: begin o = 16'd0; fl = 5'd0; end
    endcase
    return {fl, o};
  endfunction

  // ALU with one registered stage, matching ALU_LAT=1.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {shift_flag, cmp_flag, logic_flag, carry_flag, arith_flag, alu_out} <= 21'd0;
    end else begin
      {shift_flag, cmp_flag, logic_flag, carry_flag, arith_flag, alu_out} <= alu_model(alu_a, alu_b, alu_fun);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every accepted response byte is compared with the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      check("rsp_cmd_ready_low", {31'd0, cmd_ready}, 32'd0);
      if (exp_q.size() == 0) begin
        check("rsp_unexpected_byte", {24'd0, rsp_data}, 32'hFFFF_FFFF);
      end else begin
        check("rsp_byte", {24'd0, rsp_data}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  always @(negedge clk) begin
    if (watch) begin
      if (alu_fun != 4'hF) saw_non_nop = 1'b1;
      if (alu_fun == 4'h3) saw_fun3 = 1'b1;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    cmd_data = b;
    cmd_valid = 1'b1;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("cmd_accept_timeout", n, 0);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b,
                            input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
    exp_q.push_back(e0);
    exp_q.push_back(e1);
    exp_q.push_back(e2);
    send_byte(op);
    send_byte(a[7:0]);
    send_byte(a[15:8]);
    send_byte(b[7:0]);
    send_byte(b[15:8]);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check(tag, exp_q.size(), 0);
    #1;
    check("post_rsp_valid_low", {31'd0, rsp_valid}, 32'd0);
    check("post_rsp_cmd_ready", {31'd0, cmd_ready}, 32'd1);
  endtask

  initial begin
    int cyc;
    // Test 1: reset values
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_data", {24'd0, rsp_data}, 32'd0);
    check("rst_alu_a", {16'd0, alu_a}, 32'd0);
    check("rst_alu_b", {16'd0, alu_b}, 32'd0);
    check("rst_alu_fun", {28'd0, alu_fun}, 32'hF);
    check("rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;

    // Test 2: add with latency measurement
    send_frame(8'h00, 16'd5, 16'd6, 8'h0B, 8'h00, 8'h01);
    cyc = 0;
    while (!rsp_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) begin
        check("exec_alu_fun", {28'd0, alu_fun}, 32'h0);
        check("exec_alu_a", {16'd0, alu_a}, 32'd5);
        check("exec_alu_b", {16'd0, alu_b}, 32'd6);
        check("exec_busy", {31'd0, busy}, 32'd1);
        check("exec_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      end
    end
    check("add_latency", cyc, 3);
    drain("add_drain");

    // Test 3: subtract with borrow
    send_frame(8'h01, 16'd5, 16'd6, 8'hFF, 8'hFF, 8'h03);
    drain("sub_drain");
    check("hold_alu_a", {16'd0, alu_a}, 32'd5);
    check("nop_alu_fun", {28'd0, alu_fun}, 32'hF);
    check("idle_busy", {31'd0, busy}, 32'd0);

    // Test 4: compare less-than with response back-pressure
    rsp_ready = 1'b0;
    send_frame(8'h0C, 16'd5, 16'd6, 8'h03, 8'h00, 8'h08);
    cyc = 0;
    while (!rsp_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    repeat (4) begin
      @(negedge clk);
      check("stall_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("stall_rsp_data", {24'd0, rsp_data}, 32'h03);
      check("stall_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    drain("cmp_drain");

    // Test 5: reset mid-frame discards the partial frame
    send_byte(8'h02);
    send_byte(8'h05);
    check("mid_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_alu_a", {16'd0, alu_a}, 32'd0);
    check("mid_rst_alu_fun", {28'd0, alu_fun}, 32'hF);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_frame(8'h02, 16'd5, 16'd6, 8'h1E, 8'h00, 8'h01);
    drain("mul_drain");

    // Test 6: divide by zero
    saw_non_nop = 1'b0;
    saw_fun3 = 1'b0;
    watch = 1'b1;
`ifdef ALU_CMD_DIV0_CHK_EN
    send_frame(8'h03, 16'h0010, 16'h0000, 8'hFF, 8'hFF, 8'h80);
    drain("div0_drain");
    watch = 1'b0;
    check("div0_fun_nop", {31'd0, saw_non_nop}, 32'd0);
`else
    send_frame(8'h03, 16'h0010, 16'h0000, 8'h00, 8'h00, 8'h01);
    drain("div0_drain");
    watch = 1'b0;
    check("div0_fun3_issued", {31'd0, saw_fun3}, 32'd1);
`endif

    // Upper opcode bits ignored; add overflow sets carry
    send_frame(8'hF0, 16'hFFFF, 16'h0001, 8'h00, 8'h00, 8'h03);
    drain("ovf_drain");

    // NOP opcode still yields a full response
    send_frame(8'h0F, 16'h1234, 16'h5678, 8'h00, 8'h00, 8'h00);
    drain("nop_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
